// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Time-multiplexed N-digit BCD to 7-segment display driver. A packed BCD
//   word, decimal-point requests and blink mask are captured into shadow
//   registers. One digit is driven per scan slot on a shared segment bus with
//   per-digit active-low enables. Optional features are leading-zero blanking,
//   per-digit blink and invalid-code blanking.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        synchronous reset, active-low
//     bcd_in       packed BCD, digit i = bcd_in[4*i+3:4*i]
//     load         capture bcd_in, dp_in, blink_mask into shadow registers
//     blank_lz_en  blank leading zeros (live input, not captured)
//     dp_in        decimal point request per digit, 1 = on
//     blink_mask   1 = digit blinks
//     seg          {a,b,c,d,e,f,g}, active-low, registered
//     dp           decimal point, active-low, registered
//     an           digit enables, active-low, at most one low, registered
//     frame_done   one-cycle pulse on the slot tick that wraps the scan to digit 0
module bcd_scan_display #(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned BLINK_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  load,
  input  logic                  blank_lz_en,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1)    ? $clog2(CLK_DIV)  : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1)   ? $clog2(N_DIGITS) : 1;
  localparam int unsigned FRM_W = (BLINK_LOG2 > 0) ? BLINK_LOG2       : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] sh_bcd;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blink;

  logic [DIV_W-1:0]      div_q;
  logic [IDX_W-1:0]      idx_q;
  logic [FRM_W-1:0]      frame_q;
  logic                  phase_q;

  logic                  tick;
  logic                  wrap;
  logic                  frame_roll;

  logic [N_DIGITS-1:0]   hi_zero;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [N_DIGITS-1:0]   an_d;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick       = (div_q == DIV_LAST);
  assign wrap       = tick && (idx_q == IDX_LAST);
  // A zero-width frame counter is modelled as one that rolls over every frame.
  assign frame_roll = (BLINK_LOG2 == 0) || (&frame_q);
  // Gated by rst_n so the pulse stays low while reset is held, even in the
  // degenerate one-digit, divide-by-one configuration where wrap is constant.
  assign frame_done = rst_n && wrap;

  always_comb begin
    // hi_zero[i]: digits i..N_DIGITS-1 are all zero.
    hi_zero = '0;
    hi_zero[N_DIGITS-1] = (sh_bcd[4*(N_DIGITS-1) +: 4] == 4'd0);
    for (int unsigned i = N_DIGITS - 1; i > 0; i--) begin
      hi_zero[i-1] = hi_zero[i] && (sh_bcd[4*(i-1) +: 4] == 4'd0);
    end

    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        if (!((blank_lz_en && (i > 0) && hi_zero[i]) ||
              (sh_blink[i] && phase_q))) begin
          seg_d    = decode(sh_bcd[4*i +: 4]);
          dp_d     = ~sh_dp[i];
          an_d[i]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_bcd   <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      an       <= '1;
    end else begin
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;

      if (load) begin
        sh_bcd   <= bcd_in;
        sh_dp    <= dp_in;
        sh_blink <= blink_mask;
      end

      if (tick) begin
        div_q <= '0;
        idx_q <= wrap ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end

      if (wrap) begin
        frame_q <= (BLINK_LOG2 == 0) ? '0 : frame_q + 1'b1;
        if (frame_roll) begin
          phase_q <= ~phase_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display
//   Self-checking bench for bcd_scan_display (N_DIGITS=4, CLK_DIV=4,
//   BLINK_LOG2=1). A cycle model predicts the registered outputs for every
//   edge; predictions are queued when the stimulus is applied and popped and
//   compared one time unit after the edge.
module tb_bcd_scan_display;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*N-1:0] bcd_in;
  logic           load;
  logic           blank_lz_en;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   blink_mask;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           frame_done;

  bcd_scan_display #(
    .N_DIGITS  (N),
    .CLK_DIV   (DIV),
    .BLINK_LOG2(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .blank_lz_en(blank_lz_en),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         fd;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;

  // model state
  int             m_div, m_idx, m_frame;
  bit             m_phase;
  logic [4*N-1:0] m_bcd;
  logic [N-1:0]   m_dp, m_blink;

  logic [6:0] seg_tab [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] m_digit(input int i);
    logic [4*N-1:0] w;
    w = m_bcd;
    return w[4*i +: 4];
  endfunction

  // Applies one clock with the currently driven inputs.
  task automatic step();
    exp_t e;
    bit   all_zero;
    if (!rst_n) begin
      e = '{seg: 7'h7F, dp: 1'b1, an: '1, fd: 1'b0};
      m_div = 0; m_idx = 0; m_frame = 0; m_phase = 0;
      m_bcd = '0; m_dp = '0; m_blink = '0;
    end else begin
      all_zero = 1;
      for (int k = m_idx; k < N; k++) if (m_digit(k) != 0) all_zero = 0;
      if ((blank_lz_en && m_idx > 0 && all_zero) || (m_blink[m_idx] && m_phase)) begin
        e.seg = 7'h7F; e.dp = 1'b1; e.an = '1;
      end else begin
        e.seg = seg_tab[m_digit(m_idx)];
        e.dp  = ~m_dp[m_idx];
        e.an  = '1;
        e.an[m_idx] = 1'b0;
      end
      if (load) begin
        m_bcd = bcd_in; m_dp = dp_in; m_blink = blink_mask;
      end
      if (m_div == DIV - 1) begin
        m_div = 0;
        if (m_idx == N - 1) begin
          m_idx = 0;
          if (m_frame == 1) m_phase = ~m_phase;
          m_frame = (m_frame + 1) % 2;
        end else begin
          m_idx = m_idx + 1;
        end
      end else begin
        m_div = m_div + 1;
      end
    end
    e.fd = rst_n && (m_div == DIV - 1) && (m_idx == N - 1);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("seg", 32'(seg), 32'(e.seg));
    check("dp", 32'(dp), 32'(e.dp));
    check("an", 32'(an), 32'(e.an));
    check("frame_done", 32'(frame_done), 32'(e.fd));
    check("an_onehot_cold", 32'($countones(~an) <= 1), 32'd1);
    if (frame_done) fd_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] bm);
    bcd_in = b; dp_in = d; blink_mask = bm; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int fd_start;
    int guard;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    rst_n = 1'b0; bcd_in = '0; load = 1'b0; blank_lz_en = 1'b0;
    dp_in = '0; blink_mask = '0;

    // reset held for three edges
    run(3);

    // plain scan of 1234
    rst_n = 1'b1;
    do_load(16'h1234, 4'b0000, 4'b0000);
    fd_start = fd_seen;
    run(64);
    check("frame_count_64clk", 32'(fd_seen - fd_start), 32'd4);

    // leading-zero blanking
    blank_lz_en = 1'b1;
    do_load(16'h0105, 4'b0000, 4'b0000);
    run(20);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(20);

    // invalid codes and decimal point
    do_load(16'hA9F0, 4'b0100, 4'b0000);
    run(20);

    // blink digit 0: two frames lit, two frames dark
    do_load(16'hA9F0, 4'b0100, 4'b0001);
    run(16 * 6);

    // reset in the middle of digit 2's slot
    guard = 0;
    while (!(m_idx == 2 && m_div == 1) && guard < 100) begin
      step();
      guard++;
    end
    check("reach_digit2_midslot", 32'(guard < 100), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(20);

    // randomized loads, held loads and blanking toggles
    for (int i = 0; i < 200; i++) begin
      bcd_in      = 16'($urandom);
      dp_in       = 4'($urandom);
      blink_mask  = 4'($urandom);
      load        = ($urandom_range(0, 7) == 0);
      blank_lz_en = 1'($urandom);
      step();
    end
    load = 1'b0;
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
